// File: rtl/gtx_link_sim.sv
// gtx_link_sim: behavioural GTX receiver model cycling NOISE -> COMMA -> DATA
// Parameters: NB bytes per word (1..4), ALIGN_CYC comma words before data,
//             SEED nonzero initial LFSR value.
// Ports: clk, rst_n (async active-low), link_up (low forces noise),
//        tx_d/tx_k (data passed through while aligned),
//        gtx_d/gtx_k/gtx_e/gtx_n (registered decoded word, k, disperr, notintable),
//        aligned (registered, high for words produced in DATA),
//        err_inject (only with GTX_LINK_SIM_ERRINJ_EN: flags byte 0 of a DATA word).
// Optional feature macro: GTX_LINK_SIM_ERRINJ_EN
module gtx_link_sim #(
  parameter int          NB        = 2,
  parameter int          ALIGN_CYC = 16,
  parameter logic [63:0] SEED      = 64'h1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            link_up,
  input  logic [8*NB-1:0] tx_d,
  input  logic [NB-1:0]   tx_k,
`ifdef GTX_LINK_SIM_ERRINJ_EN
  input  logic            err_inject,
`endif
  output logic [8*NB-1:0] gtx_d,
  output logic [NB-1:0]   gtx_k,
  output logic [NB-1:0]   gtx_e,
  output logic [NB-1:0]   gtx_n,
  output logic            aligned
);
  typedef enum logic [1:0] {NOISE, COMMA, DATA} state_t;
  state_t          state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [63:0]     lfsr_q, lfsr_d;
  logic [8*NB-1:0] d_q, d_d;
  logic [NB-1:0]   k_q, k_d, e_q, e_d, n_q, n_d;
  logic            al_q, al_d;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lfsr_d  = {lfsr_q[62:0], lfsr_q[63] ^ lfsr_q[62] ^ lfsr_q[60] ^ lfsr_q[59]};
    // link loss wins over everything and discards any partial comma run
    if (!link_up) begin
      state_d = NOISE;
      cnt_d   = '0;
    end else if (state_q == NOISE) begin
      state_d = COMMA;
      cnt_d   = '0;
    end else if (state_q == COMMA) begin
      if (cnt_q == 16'(ALIGN_CYC - 1)) state_d = DATA;
      else cnt_d = cnt_q + 16'd1;
    end
    // output word is built from the state held before the edge
    d_d  = '0;
    k_d  = '0;
    e_d  = '0;
    n_d  = '0;
    al_d = 1'b0;
    if (state_q == NOISE) begin
      for (int i = 0; i < NB; i++) begin
        d_d[8*i +: 8] = lfsr_q[8*i +: 8];
        k_d[i]        = lfsr_q[32+i];
        e_d[i]        = lfsr_q[40+i] & lfsr_q[44+i];
        n_d[i]        = lfsr_q[48+i] & lfsr_q[52+i];
      end
    end else if (state_q == COMMA) begin
      d_d        = {NB{8'h50}};
      d_d[7:0]   = 8'hBC;
      k_d[0]     = 1'b1;
    end else begin
      d_d  = tx_d;
      k_d  = tx_k;
      al_d = 1'b1;
`ifdef GTX_LINK_SIM_ERRINJ_EN
      e_d[0] = err_inject;
      n_d[0] = err_inject;
`endif
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= NOISE;
      cnt_q   <= '0;
      lfsr_q  <= SEED;
      d_q     <= '0;
      k_q     <= '0;
      e_q     <= '0;
      n_q     <= '0;
      al_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      d_q     <= d_d;
      k_q     <= k_d;
      e_q     <= e_d;
      n_q     <= n_d;
      al_q    <= al_d;
    end
  end
  assign gtx_d   = d_q;
  assign gtx_k   = k_q;
  assign gtx_e   = e_q;
  assign gtx_n   = n_q;
  assign aligned = al_q;
endmodule

// File: tb/tb_gtx_link_sim.sv
// tb_gtx_link_sim: directed vector bench for gtx_link_sim (NB=2, ALIGN_CYC=4, SEED=1)
module tb_gtx_link_sim;
  localparam int NB = 2;
  typedef struct {
    logic        lu;
    logic [15:0] td;
    logic [1:0]  tk;
    int          kind;
    logic [15:0] ed;
    logic [1:0]  ek;
  } vec_t;
  logic        clk = 1'b0, rst_n = 1'b0, link_up = 1'b0, err_inject = 1'b0;
  logic [15:0] tx_d = '0;
  logic [1:0]  tx_k = '0;
  logic [15:0] gtx_d;
  logic [1:0]  gtx_k, gtx_e, gtx_n;
  logic        aligned;
  int          errors = 0, checks = 0;
  logic [63:0] m_lfsr = 64'h1;
  logic [15:0] nd;
  logic [1:0]  nk, ne, nn;
  vec_t        tv[$];
  always #5 clk = ~clk;
  gtx_link_sim #(.NB(NB), .ALIGN_CYC(4), .SEED(64'h1)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .link_up(link_up),
    .tx_d(tx_d),
    .tx_k(tx_k),
`ifdef GTX_LINK_SIM_ERRINJ_EN
    .err_inject(err_inject),
`endif
    .gtx_d(gtx_d),
    .gtx_k(gtx_k),
    .gtx_e(gtx_e),
    .gtx_n(gtx_n),
    .aligned(aligned)
  );
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask
  // advance one edge; nd..nn hold the noise word the model expects for that edge
  task automatic tick();
    @(posedge clk);
    #1;
    nd = m_lfsr[15:0];
    nk = {m_lfsr[33], m_lfsr[32]};
    ne = {m_lfsr[41] & m_lfsr[45], m_lfsr[40] & m_lfsr[44]};
    nn = {m_lfsr[49] & m_lfsr[53], m_lfsr[48] & m_lfsr[52]};
    m_lfsr = {m_lfsr[62:0], m_lfsr[63] ^ m_lfsr[62] ^ m_lfsr[60] ^ m_lfsr[59]};
  endtask
  // kind: 0 noise, 1 comma, 2 data
  task automatic word(input string tag, input int kind, input logic [15:0] ed, input logic [1:0] ek,
                      input logic [1:0] ee, input logic [1:0] en);
    if (kind == 0) begin
      chk({tag, " d"}, gtx_d, nd);
      chk({tag, " k"}, 16'(gtx_k), 16'(nk));
      chk({tag, " e"}, 16'(gtx_e), 16'(ne));
      chk({tag, " n"}, 16'(gtx_n), 16'(nn));
    end else begin
      chk({tag, " d"}, gtx_d, ed);
      chk({tag, " k"}, 16'(gtx_k), 16'(ek));
      chk({tag, " e"}, 16'(gtx_e), 16'(ee));
      chk({tag, " n"}, 16'(gtx_n), 16'(en));
    end
    chk({tag, " aligned"}, 16'(aligned), 16'(kind == 2));
  endtask
  task automatic zeros(input string tag);
    chk({tag, " d"}, gtx_d, 16'h0);
    chk({tag, " k"}, 16'(gtx_k), 16'h0);
    chk({tag, " e"}, 16'(gtx_e), 16'h0);
    chk({tag, " n"}, 16'(gtx_n), 16'h0);
    chk({tag, " aligned"}, 16'(aligned), 16'h0);
  endtask
  function automatic vec_t v(input logic lu, input int kind, input logic [15:0] td = 16'h0,
                             input logic [1:0] tk = 2'b00);
    vec_t r;
    r.lu   = lu;
    r.td   = td;
    r.tk   = tk;
    r.kind = kind;
    r.ed   = (kind == 1) ? 16'h50BC : td;
    r.ek   = (kind == 1) ? 2'b01 : tk;
    return r;
  endfunction
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    // idle noise, then a comma run into data
    tv.push_back(v(0, 0));
    tv.push_back(v(0, 0));
    tv.push_back(v(1, 0));
    for (int i = 0; i < 4; i++) tv.push_back(v(1, 1));
    tv.push_back(v(1, 2, 16'h1234, 2'b00));
    tv.push_back(v(1, 2, 16'hABCD, 2'b10));
    // one-cycle link drop in data: data word, one noise word, full comma run
    tv.push_back(v(0, 2, 16'h5555, 2'b11));
    tv.push_back(v(1, 0));
    for (int i = 0; i < 4; i++) tv.push_back(v(1, 1));
    tv.push_back(v(1, 2, 16'hBEEF, 2'b01));
    tv.push_back(v(1, 2, 16'h0000, 2'b11));
    // link drop after two comma words restarts a full comma run
    tv.push_back(v(0, 2, 16'hC0DE, 2'b00));
    tv.push_back(v(1, 0));
    tv.push_back(v(1, 1));
    tv.push_back(v(0, 1));
    tv.push_back(v(1, 0));
    for (int i = 0; i < 4; i++) tv.push_back(v(1, 1));
    tv.push_back(v(1, 2, 16'h1234, 2'b00));
    tv.push_back(v(0, 2, 16'h9876, 2'b01));
    tv.push_back(v(0, 0));
    tv.push_back(v(0, 0));
    #12;
    zeros("reset");
    rst_n = 1'b1;
    m_lfsr = 64'h1;
    for (int i = 0; i < tv.size(); i++) begin
      link_up = tv[i].lu;
      tx_d    = tv[i].td;
      tx_k    = tv[i].tk;
      tick();
      word($sformatf("v%0d", i), tv[i].kind, tv[i].ed, tv[i].ek, 2'b00, 2'b00);
      if (i == 0) chk("first_word", gtx_d, 16'h0001);
    end
    // asynchronous reset in the middle of DATA
    link_up = 1'b1;
    tick();
    word("pre_rst_noise", 0, 16'h0, 2'b00, 2'b00, 2'b00);
    for (int i = 0; i < 4; i++) begin
      tick();
      word($sformatf("pre_rst_comma%0d", i), 1, 16'h50BC, 2'b01, 2'b00, 2'b00);
    end
    tx_d = 16'h4321;
    tx_k = 2'b10;
    tick();
    word("pre_rst_data", 2, 16'h4321, 2'b10, 2'b00, 2'b00);
    #2;
    rst_n = 1'b0;
    #1;
    zeros("async_rst");
    @(posedge clk);
    #1;
    zeros("held_rst");
    link_up = 1'b0;
    rst_n = 1'b1;
    m_lfsr = 64'h1;
    tick();
    chk("post_rst_first", gtx_d, 16'h0001);
    word("post_rst0", 0, 16'h0, 2'b00, 2'b00, 2'b00);
    tick();
    word("post_rst1", 0, 16'h0, 2'b00, 2'b00, 2'b00);
`ifdef GTX_LINK_SIM_ERRINJ_EN
    link_up = 1'b1;
    tick();
    word("ei_noise", 0, 16'h0, 2'b00, 2'b00, 2'b00);
    for (int i = 0; i < 4; i++) begin
      err_inject = (i == 1);
      tick();
      word($sformatf("ei_comma%0d", i), 1, 16'h50BC, 2'b01, 2'b00, 2'b00);
    end
    err_inject = 1'b1;
    tx_d = 16'hA5A5;
    tx_k = 2'b00;
    tick();
    word("ei_data_err", 2, 16'hA5A5, 2'b00, 2'b01, 2'b01);
    err_inject = 1'b0;
    tx_d = 16'h5A5A;
    tick();
    word("ei_data_clean", 2, 16'h5A5A, 2'b00, 2'b00, 2'b00);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/gtx_link_sim.md
GTX_LINK_SIM -- requirements
Module: gtx_link_sim

Interface
REQ-001 Parameter NB, default 2: bytes per word, legal range 1..4.
REQ-002 Parameter ALIGN_CYC, default 16: number of comma words sent before data, legal range 1..65535.
REQ-003 Parameter SEED, default 64'h1: initial LFSR value; must be nonzero.
REQ-004 clk  input  1: single clock; all outputs and state are updated on its rising edge.
REQ-005 rst_n  input  1: reset, asynchronous, active-low.
REQ-006 link_up  input  1: requests link up; low forces the noise state.
REQ-007 tx_d  input  8*NB: data to pass through in the DATA state.
REQ-008 tx_k  input  NB: charisk to pass through in the DATA state.
REQ-009 gtx_d  output  8*NB: decoded data; byte i is gtx_d[8i+7:8i].
REQ-010 gtx_k  output  NB: charisk, one bit per byte.
REQ-011 gtx_e  output  NB: disperr, one bit per byte.
REQ-012 gtx_n  output  NB: notintable, one bit per byte.
REQ-013 aligned  output  1: high while the state is DATA.

Function
REQ-014 The block SHALL hold a 3-state FSM: NOISE, COMMA and DATA.
REQ-015 NOISE -> COMMA SHALL occur on an edge that samples link_up=1; the comma counter loads 0 on that edge.
REQ-016 COMMA -> DATA SHALL occur on the edge where the counter equals ALIGN_CYC-1; otherwise the counter increments.
REQ-017 Any state -> NOISE SHALL occur on an edge that samples link_up=0; this takes priority over every other transition.
REQ-018 The 64-bit LFSR SHALL step once per edge in all states: shift left, bit0 = b63^b62^b60^b59.
REQ-019 Output registers SHALL load from the FSM state held before the edge, so the first COMMA word appears one edge after the NOISE->COMMA edge.
REQ-020 NOISE outputs per byte i:
- gtx_d byte i = lfsr[8i+7:8i]
- gtx_k[i] = lfsr[32+i]
- gtx_e[i] = lfsr[40+i] & lfsr[44+i]
- gtx_n[i] = lfsr[48+i] & lfsr[52+i]
- all fields use the LFSR value before the step.
REQ-021 COMMA outputs:
- byte0 = 8'hBC with k=1 (K28.5)
- bytes 1..NB-1 = 8'h50 with k=0
- gtx_e = 0, gtx_n = 0.
REQ-022 DATA outputs: gtx_d = tx_d and gtx_k = tx_k as sampled at the same edge (one-cycle latency); gtx_e = 0 and gtx_n = 0, except as stated in REQ-027.
REQ-023 aligned SHALL be registered and equal 1 exactly in the cycles whose outputs came from DATA.
REQ-024 If link_up is deasserted during COMMA, the counter SHALL be discarded, and the next assertion restarts a full ALIGN_CYC comma run.

Reset
REQ-025 While rst_n=0 the block SHALL force:
- state = NOISE, counter = 0, LFSR = SEED
- gtx_d = 0, gtx_k = 0, gtx_e = 0, gtx_n = 0, aligned = 0.
REQ-026 After rst_n deasserts mid-operation, behaviour SHALL be identical to that after power-up reset, including the LFSR sequence.

Configuration
REQ-027 With macro GTX_LINK_SIM_ERRINJ_EN defined:
- input port err_inject (1 bit) exists
- a DATA-state edge sampling err_inject=1 SHALL set gtx_e[0]=1 and gtx_n[0]=1 in that output word; data and k are unchanged
- err_inject SHALL be ignored in NOISE and COMMA.
REQ-028 Without GTX_LINK_SIM_ERRINJ_EN the port SHALL be absent, and gtx_e and gtx_n SHALL be 0 outside NOISE.

Verification
REQ-029 Reset with SEED=1, NB=2, link_up=0 -> first post-reset word:
- gtx_d=16'h0001, gtx_k=0, gtx_e=0, gtx_n=0
- subsequent words follow a software LFSR model bit-exactly.
REQ-030 NB=2, ALIGN_CYC=4: raise link_up -> after one edge:
- exactly 4 words of gtx_d=16'h50BC with gtx_k=2'b01
- then tx_d=16'h1234 appears with one-cycle latency and aligned=1.
REQ-031 Drop link_up after 2 comma words, then re-raise it -> noise resumes on the next word, followed by a full run of 4 comma words.
REQ-032 In DATA, drop link_up for one cycle -> aligned=0 and noise for one word, then 4 comma words, then data again.
REQ-033 With GTX_LINK_SIM_ERRINJ_EN, NB=4: err_inject pulse in DATA -> that word only has gtx_e=4'b0001 and gtx_n=4'b0001; the same pulse in COMMA -> flags stay 0.
REQ-034 Assert rst_n=0 asynchronously mid-DATA -> outputs are 0 immediately (before the next edge); after release the LFSR restarts from SEED.
